// File: rtl/ser_pkg.sv
// Shared types and helpers for the byte serializer feed.
// Provides the FSM state encoding and a counter-width helper that never returns zero.
package ser_pkg;

  typedef enum logic [1:0] {
    SER_IDLE,
    SER_SHIFT,
    SER_GAP
  } ser_state_t;

  localparam int SER_WIDTH_DEF = 8;

  // $clog2 returns 0 for n<=1; a counter still needs at least one bit.
  function automatic int ser_cnt_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/ser_gap_timer.sv
// Inter-bit gap down-counter: loaded with GAP_CYCLES, 'expire' marks the final gap cycle.
// Only instantiated when SER_BITGAP_EN is defined.
module ser_gap_timer
  import ser_pkg::*;
#(
  parameter int GAP_CYCLES = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  output logic expire
);

  localparam int CW = ser_cnt_w(GAP_CYCLES + 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      cnt <= '0;
    else if (load)
      cnt <= CW'(GAP_CYCLES);
    else if (cnt != '0)
      cnt <= cnt - 1'b1;
  end

  assign expire = (cnt == CW'(1));

endmodule

// File: rtl/byte_serializer_feed.sv
// Parallel-to-serial feeder: accepts WIDTH-bit words on valid/ready and shifts them out MSB-first.
// Optional inter-bit idle gaps are enabled by defining SER_BITGAP_EN.
module byte_serializer_feed
  import ser_pkg::*;
#(
  parameter int WIDTH      = SER_WIDTH_DEF,
  parameter int GAP_CYCLES = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             s_out,
  output logic             shift_en,
  output logic             busy,
  output logic             frame_done
);

  localparam int CW = ser_cnt_w(WIDTH);

  ser_state_t       state, next_state;
  logic [WIDTH-1:0] hold;
  logic [CW-1:0]    bit_cnt;
  logic             last_bit;
  logic             accept;

  assign last_bit = (state == SER_SHIFT) && (bit_cnt == CW'(WIDTH - 1));
  assign accept   = in_valid & in_ready;

`ifdef SER_BITGAP_EN
  logic gap_expire;

  ser_gap_timer #(
    .GAP_CYCLES(GAP_CYCLES)
  ) u_gap_timer (
    .clk   (clk),
    .reset (reset),
    .load  ((state == SER_SHIFT) && !last_bit),
    .expire(gap_expire)
  );
`else
  logic unused_gap_cfg;
  assign unused_gap_cfg = ^GAP_CYCLES;
`endif

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      state <= SER_IDLE;
    else
      state <= next_state;
  end

  // NOTE: default assignment first so no path through the case leaves next_state unassigned (no latch).
  always_comb begin
    next_state = state;
    case (state)
      SER_IDLE:  if (accept) next_state = SER_SHIFT;
      SER_SHIFT: begin
        if (last_bit)
          next_state = accept ? SER_SHIFT : SER_IDLE;
        else
`ifdef SER_BITGAP_EN
          next_state = SER_GAP;
`else
          next_state = SER_SHIFT;
`endif
      end
`ifdef SER_BITGAP_EN
      SER_GAP:   if (gap_expire) next_state = SER_SHIFT;
`else
      SER_GAP:   next_state = SER_IDLE;
`endif
      default:   next_state = SER_IDLE;
    endcase
  end

  // Outputs decode from registered state only; no combinational path from in_valid/in_data.
  always_comb begin
    shift_en = (state == SER_SHIFT);
    s_out    = (state != SER_IDLE) & hold[WIDTH-1];
    busy     = (state != SER_IDLE);
    in_ready = (state == SER_IDLE) | last_bit;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hold       <= '0;
      bit_cnt    <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= last_bit;
      if (accept) begin
        hold    <= in_data;
        bit_cnt <= '0;
      end else if (state == SER_SHIFT) begin
        hold    <= {hold[WIDTH-2:0], 1'b0};
        bit_cnt <= last_bit ? '0 : bit_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_byte_serializer_feed.sv
// Directed bench for byte_serializer_feed, including a model of the downstream shift register / read mux.
// Define SER_BITGAP_EN to run the gapped-enable scenario instead of the default set.
module tb_byte_serializer_feed;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic       s_out;
  logic       shift_en;
  logic       busy;
  logic       frame_done;

  int n_checks = 0;
  int n_pass   = 0;

  byte_serializer_feed #(
    .WIDTH     (8),
    .GAP_CYCLES(2)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .s_out     (s_out),
    .shift_en  (shift_en),
    .busy      (busy),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  // Downstream 8-bit serial-in register: S=s_out, enable=shift_en; Z = q[{A,B,C}].
  logic [7:0] q = '0;
  always_ff @(posedge clk) if (shift_en) q <= {q[6:0], s_out};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Accept a word in the current cycle; returns just after the capturing edge with valid dropped.
  task automatic send(input logic [7:0] w);
    in_data  = w;
    in_valid = 1'b1;
    check("ready_before_accept", in_ready, 1'b1);
    cyc();
    in_valid = 1'b0;
  endtask

  logic [7:0]  w8;
  logic [15:0] w16;

  initial begin
    reset    = 1'b1;
    in_data  = '0;
    in_valid = 1'b0;
    #1;
    check("rst_shift_en", shift_en, 1'b0);
    check("rst_s_out",    s_out,    1'b0);
    check("rst_busy",     busy,     1'b0);
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_frame",    frame_done, 1'b0);
    cyc();
    cyc();
    reset = 1'b0;
    cyc();

`ifdef SER_BITGAP_EN
    // Gapped enables, GAP_CYCLES=2: pattern 1,0,0,... ending in 1, 22 cycles.
    w8 = 8'hF0;
    send(w8);
    for (int i = 0; i < 22; i++) begin
      check("gap_shift_en", shift_en, (i % 3) == 0);
      check("gap_s_out", s_out, w8[7 - (i + 2) / 3]);
      check("gap_ready", in_ready, i == 21);
      cyc();
    end
    check("gap_frame_done", frame_done, 1'b1);
    check("gap_idle", busy, 1'b0);
`else
    // Single word 0xA5.
    w8 = 8'hA5;
    send(w8);
    for (int i = 0; i < 8; i++) begin
      check("single_shift_en", shift_en, 1'b1);
      check("single_s_out", s_out, w8[7 - i]);
      check("single_frame", frame_done, 1'b0);
      check("single_busy", busy, 1'b1);
      cyc();
    end
    check("single_frame_done", frame_done, 1'b1);
    check("single_shift_off", shift_en, 1'b0);
    check("single_ready_after", in_ready, 1'b1);
    check("single_busy_after", busy, 1'b0);
    cyc();
    check("single_frame_1cyc", frame_done, 1'b0);

    // End-to-end read mux sweep: Z[k] equals bit k of 0xA5.
    w8 = 8'b1010_0101;
    for (int k = 0; k < 8; k++) check("mux_z", q[k], w8[k]);

    // Back-to-back 0x3C then 0xC3 with valid held.
    w16 = 16'h3CC3;
    send(8'h3C);
    in_data  = 8'hC3;
    in_valid = 1'b1;
    for (int i = 0; i < 16; i++) begin
      if (i == 8) in_valid = 1'b0;
      check("b2b_shift_en", shift_en, 1'b1);
      check("b2b_s_out", s_out, w16[15 - i]);
      check("b2b_frame", frame_done, i == 8);
      if (i < 8) check("b2b_ready", in_ready, i == 7);
      cyc();
    end
    check("b2b_frame_end", frame_done, 1'b1);
    check("b2b_idle", shift_en, 1'b0);

    // Backpressure: 0xFF offered at bit 3 of 0x66, taken only at the last bit.
    w16 = 16'h66FF;
    send(8'h66);
    for (int i = 0; i < 16; i++) begin
      if (i == 3) begin
        in_data  = 8'hFF;
        in_valid = 1'b1;
      end
      if (i == 8) in_valid = 1'b0;
      check("bp_shift_en", shift_en, 1'b1);
      check("bp_s_out", s_out, w16[15 - i]);
      if (i < 8) check("bp_ready", in_ready, i == 7);
      cyc();
    end
    check("bp_frame_end", frame_done, 1'b1);
    check("bp_idle", busy, 1'b0);
    cyc();

    // Reset during bit 4 of 0x5A, then a simultaneous reset/accept, then 0x81.
    w8 = 8'h5A;
    send(w8);
    for (int i = 0; i < 4; i++) cyc();
    check("rmid_bit4", s_out, w8[3]);
    check("rmid_en_before", shift_en, 1'b1);
    #2 reset = 1'b1;
    #1;
    check("rmid_en_drop", shift_en, 1'b0);
    check("rmid_s_out", s_out, 1'b0);
    check("rmid_busy", busy, 1'b0);
    check("rmid_ready", in_ready, 1'b1);
    in_data  = 8'hFF;
    in_valid = 1'b1;
    cyc();
    check("rsim_no_capture", busy, 1'b0);
    reset    = 1'b0;
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("rmid_no_frame", frame_done, 1'b0);
      check("rmid_stay_idle", busy, 1'b0);
      cyc();
    end
    w8 = 8'h81;
    send(w8);
    for (int i = 0; i < 8; i++) begin
      check("post_rst_en", shift_en, 1'b1);
      check("post_rst_s_out", s_out, w8[7 - i]);
      cyc();
    end
    check("post_rst_frame", frame_done, 1'b1);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
